// File: rtl/comb_ff_pipe.sv
// -----------------------------------------------------------------------------
// comb_ff_pipe
//   Mixed combinational / flip-flop block for fault-injection campaigns.
//   Valid input samples enter a DEPTH-entry delay line. Once the line is
//   full, each new sample is ANDed with the sample DEPTH valid beats older,
//   and the result is registered. A saturating counter tracks how many
//   non-zero results have been produced.
//
//   Optional feature, enabled by defining COMB_FF_PIPE_PARITY_EN:
//     Every line entry carries an even-parity bit. The bit is recomputed for
//     the oldest entry whenever a result is produced. A mismatch sets a
//     sticky fault flag. Without the macro, fault_o is tied to 0.
//
// Parameters
//   WIDTH  data/result width in bits
//   DEPTH  delay-line length in valid beats
//   CNT_W  hit counter width in bits
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous reset, active low
//   clr_i           synchronous clear; takes priority over data_valid_i
//   data_valid_i    data_i carries a sample this cycle
//   data_i          input sample
//   result_valid_o  one-cycle pulse: result_o was updated
//   result_o        data_i & oldest line entry, registered
//   hit_cnt_o       saturating count of non-zero results
//   fault_o         sticky delay-line parity error
// -----------------------------------------------------------------------------
module comb_ff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             data_valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic             fault_o
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  HIT_MAX  = '1;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    RUN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [WIDTH-1:0]  line [DEPTH];
  logic [WIDTH-1:0]  and_val;

  // The AND uses the oldest entry as it stands before this beat shifts in.
  assign and_val = data_i & line[DEPTH-1];

  // Fill count saturates at DEPTH. The state follows from the count a valid
  // beat produces. That count is never 0, so EMPTY is left on the first beat.
  // With DEPTH=1, the first beat already reaches RUN.
  always_comb begin
    fill_next  = fill;
    state_next = FILL;
    if (fill != FILL_MAX) begin
      fill_next = fill + FILL_W'(1);
    end
    if (fill_next == FILL_MAX) begin
      state_next = RUN;
    end
  end

  // Control FSM, delay line, result register and hit counter.
  // Bubbles leave the line and the fill count alone. Only result_valid_o
  // drops back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= EMPTY;
      fill           <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      hit_cnt_o      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        line[k] <= '0;
      end
    end else if (clr_i) begin
      state          <= EMPTY;
      fill           <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      hit_cnt_o      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        line[k] <= '0;
      end
    end else if (data_valid_i) begin
      line[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        line[k] <= line[k-1];
      end
      fill  <= fill_next;
      state <= state_next;
      if (state == RUN) begin
        result_o       <= and_val;
        result_valid_o <= 1'b1;
        if ((|and_val) && (hit_cnt_o != HIT_MAX)) begin
          hit_cnt_o <= hit_cnt_o + CNT_W'(1);
        end
      end else begin
        result_valid_o <= 1'b0;
      end
    end else begin
      result_valid_o <= 1'b0;
    end
  end

`ifdef COMB_FF_PIPE_PARITY_EN
  logic [DEPTH-1:0] line_par;
  logic             fault_q;

  // Each parity bit is captured with its data and moves through the line
  // with it. The oldest entry is rechecked only on beats that produce a
  // result, so the fault appears on the same edge as result_valid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_par <= '0;
      fault_q  <= 1'b0;
    end else if (clr_i) begin
      line_par <= '0;
      fault_q  <= 1'b0;
    end else if (data_valid_i) begin
      line_par[0] <= ^data_i;
      for (int k = 1; k < DEPTH; k++) begin
        line_par[k] <= line_par[k-1];
      end
      if ((state == RUN) && ((^line[DEPTH-1]) != line_par[DEPTH-1])) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

endmodule
